// File: rtl/vmul_seq_pkg.sv
// Shared types and constants for the vector-multiply sequencer.
// Used by vmul_sequencer and vmul_seq_track.
package vmul_seq_pkg;

   localparam int MAX_VL_DEF  = 16;
   localparam int MUL_LAT_DEF = 3;

   // Layout of the 34-bit multiplier result word.
   localparam int RES_W         = 34;
   localparam int RES_VALID_BIT = 33;
   localparam int RES_MASK_BIT  = 32;
   localparam int RES_SIGN_BIT  = 31;
   localparam int RES_EXP_HI    = 30;
   localparam int RES_EXP_LO    = 23;
   localparam int RES_FRAC_HI   = 22;
   localparam int RES_FRAC_LO   = 0;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   function automatic logic [4:0] clamp_vl(input logic [4:0] v, input int max_vl);
      return (int'(v) > max_vl) ? 5'(max_vl) : v;
   endfunction

endpackage

// File: rtl/vmul_seq_track.sv
// LAT-deep delay line following each issued element (slot, write-enable, index)
// so the matching multiplier result can be identified when it emerges.
module vmul_seq_track
   import vmul_seq_pkg::*;
#(
   parameter int LAT = MUL_LAT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_slot,
   input  logic       in_wr,
   input  logic [3:0] in_idx,
   output logic       out_slot,
   output logic       out_wr,
   output logic [3:0] out_idx
);

   genvar gi;
   generate
      for (gi = 0; gi < LAT; gi++) begin : g_stage
         logic       slot_reg;
         logic       wr_reg;
         logic [3:0] idx_reg;
         logic       slot_next;
         logic       wr_next;
         logic [3:0] idx_next;

         if (gi == 0) begin : g_head
            assign slot_next = in_slot;
            assign wr_next   = in_wr;
            assign idx_next  = in_idx;
         end else begin : g_body
            assign slot_next = g_stage[gi-1].slot_reg;
            assign wr_next   = g_stage[gi-1].wr_reg;
            assign idx_next  = g_stage[gi-1].idx_reg;
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               slot_reg <= 1'b0;
               wr_reg   <= 1'b0;
               idx_reg  <= 4'd0;
            end else begin
               slot_reg <= slot_next;
               wr_reg   <= wr_next;
               idx_reg  <= idx_next;
            end
         end
      end
   endgenerate

   assign out_slot = g_stage[LAT-1].slot_reg;
   assign out_wr   = g_stage[LAT-1].wr_reg;
   assign out_idx  = g_stage[LAT-1].idx_reg;

endmodule

// File: rtl/vmul_sequencer.sv
// Sequences one vector multiply: reads elements, issues them to a fixed-latency
// multiplier and writes results back. Optional macro VMUL_SEQ_MASK_EN suppresses masked elements.
module vmul_sequencer
   import vmul_seq_pkg::*;
#(
   parameter int MAX_VL  = MAX_VL_DEF,
   parameter int MUL_LAT = MUL_LAT_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [4:0]       vl,
   input  logic [1:0]       rnd,
   output logic             rd_en,
   output logic [3:0]       rd_idx,
   input  logic [31:0]      rd_a,
   input  logic [31:0]      rd_b,
   input  logic             rd_mask,
   output logic             mul_valid,
   output logic [31:0]      mul_a,
   output logic [31:0]      mul_b,
   output logic             mul_mask,
   output logic [1:0]       mul_rnd,
   input  logic [RES_W-1:0] res_data,
   input  logic             res_exc,
   output logic             wb_en,
   output logic [3:0]       wb_idx,
   output logic [RES_W-1:0] wb_data,
   output logic             busy,
   output logic             done,
   output logic             exc_flag
);

   state_t     state_reg;
   logic [4:0] vl_reg;
   logic [1:0] rnd_reg;
   logic       rd_en_reg;
   logic [3:0] rd_idx_reg;
   logic       slot_reg;
   logic [3:0] slot_idx_reg;
   logic       exc_reg;
   logic       done_reg;
   logic       busy_reg;
   logic       start_ready_reg;

   logic       issue_wr;
   logic       emerge_slot;
   logic       emerge_wr;
   logic [3:0] emerge_idx;

   // slot_reg marks the cycle the RF data for an element is on rd_a/rd_b.
`ifdef VMUL_SEQ_MASK_EN
   assign issue_wr = slot_reg & rd_mask;
`else
   assign issue_wr = slot_reg;
`endif

   vmul_seq_track #(
      .LAT (MUL_LAT)
   ) u_track (
      .clk      (clk),
      .rst      (rst),
      .in_slot  (slot_reg),
      .in_wr    (issue_wr),
      .in_idx   (slot_idx_reg),
      .out_slot (emerge_slot),
      .out_wr   (emerge_wr),
      .out_idx  (emerge_idx)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg       <= IDLE;
         vl_reg          <= 5'd0;
         rnd_reg         <= 2'd0;
         rd_en_reg       <= 1'b0;
         rd_idx_reg      <= 4'd0;
         slot_reg        <= 1'b0;
         slot_idx_reg    <= 4'd0;
         exc_reg         <= 1'b0;
         done_reg        <= 1'b0;
         busy_reg        <= 1'b0;
         start_ready_reg <= 1'b1;
      end else begin
         slot_reg     <= rd_en_reg;
         slot_idx_reg <= rd_idx_reg;
         done_reg     <= 1'b0;
         if (emerge_wr && res_exc)
            exc_reg <= 1'b1;

         case (state_reg)
            IDLE: begin
               if (start_valid) begin
                  vl_reg          <= clamp_vl(vl, MAX_VL);
                  rnd_reg         <= rnd;
                  exc_reg         <= 1'b0;
                  start_ready_reg <= 1'b0;
                  busy_reg        <= 1'b1;
                  if (vl == 5'd0) begin
                     state_reg <= DONE;
                     done_reg  <= 1'b1;
                  end else begin
                     state_reg  <= ISSUE;
                     rd_en_reg  <= 1'b1;
                     rd_idx_reg <= 4'd0;
                  end
               end
            end
            ISSUE: begin
               if ({1'b0, rd_idx_reg} == vl_reg - 5'd1) begin
                  rd_en_reg  <= 1'b0;
                  rd_idx_reg <= 4'd0;
                  state_reg  <= DRAIN;
               end else begin
                  rd_idx_reg <= rd_idx_reg + 4'd1;
               end
            end
            DRAIN: begin
               // Last slot emerging ends the op even when it was masked off.
               if (emerge_slot && ({1'b0, emerge_idx} == vl_reg - 5'd1)) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
               end
            end
            DONE: begin
               state_reg       <= IDLE;
               busy_reg        <= 1'b0;
               start_ready_reg <= 1'b1;
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign start_ready = start_ready_reg;
   assign busy        = busy_reg;
   assign done        = done_reg;
   assign rd_en       = rd_en_reg;
   assign rd_idx      = rd_idx_reg;

   assign mul_valid = issue_wr;
   assign mul_a     = slot_reg ? rd_a : 32'd0;
   assign mul_b     = slot_reg ? rd_b : 32'd0;
   assign mul_mask  = slot_reg & rd_mask;
   assign mul_rnd   = rnd_reg;

   assign wb_en    = emerge_wr;
   assign wb_idx   = emerge_wr ? emerge_idx : 4'd0;
   assign wb_data  = emerge_wr ? res_data : '0;
   assign exc_flag = exc_reg | (emerge_wr & res_exc);

endmodule

// File: tb/tb_vmul_sequencer.sv
// Directed bench for vmul_sequencer with a register-file model and a fixed-latency
// multiplier model; honours VMUL_SEQ_MASK_EN when it is defined.
module tb_vmul_sequencer;
   import vmul_seq_pkg::*;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_valid = 1'b0;
   logic        start_ready;
   logic [4:0]  vl = 5'd0;
   logic [1:0]  rnd = 2'd0;
   logic        rd_en;
   logic [3:0]  rd_idx;
   logic [31:0] rd_a, rd_b;
   logic        rd_mask;
   logic        mul_valid;
   logic [31:0] mul_a, mul_b;
   logic        mul_mask;
   logic [1:0]  mul_rnd;
   logic [33:0] res_data;
   logic        res_exc;
   logic        wb_en;
   logic [3:0]  wb_idx;
   logic [33:0] wb_data;
   logic        busy, done, exc_flag;

   int n_tests = 0;
   int n_fail  = 0;

   logic [15:0] mask_pat    = 16'hFFFF;
   logic        exc_en      = 1'b0;
   logic [3:0]  exc_sel     = 4'd0;
   logic        garbage_exc = 1'b1;

   always #5 clk = ~clk;

   vmul_sequencer dut (
      .clk(clk), .rst(rst),
      .start_valid(start_valid), .start_ready(start_ready),
      .vl(vl), .rnd(rnd),
      .rd_en(rd_en), .rd_idx(rd_idx), .rd_a(rd_a), .rd_b(rd_b), .rd_mask(rd_mask),
      .mul_valid(mul_valid), .mul_a(mul_a), .mul_b(mul_b), .mul_mask(mul_mask), .mul_rnd(mul_rnd),
      .res_data(res_data), .res_exc(res_exc),
      .wb_en(wb_en), .wb_idx(wb_idx), .wb_data(wb_data),
      .busy(busy), .done(done), .exc_flag(exc_flag)
   );

   // Register file: data one cycle after rd_en, element index encoded in rd_a.
   always_ff @(posedge clk) begin
      rd_a    <= rd_en ? (32'h1000_0000 | 32'(rd_idx)) : 32'hDEAD_BEEF;
      rd_b    <= rd_en ? 32'h0000_0A00 : 32'h5555_5555;
      rd_mask <= rd_en ? mask_pat[rd_idx] : 1'b1;
   end

   // Multiplier: result LAT cycles after mul_valid; junk (exc=1) when idle.
   logic        mv_pipe [LAT];
   logic [33:0] md_pipe [LAT];
   logic        me_pipe [LAT];
   always_ff @(posedge clk) begin
      mv_pipe[0] <= mul_valid;
      md_pipe[0] <= {1'b1, mul_mask, mul_a ^ mul_b};
      me_pipe[0] <= mul_valid && exc_en && (mul_a[3:0] == exc_sel);
      for (int k = 1; k < LAT; k++) begin
         mv_pipe[k] <= mv_pipe[k-1];
         md_pipe[k] <= md_pipe[k-1];
         me_pipe[k] <= me_pipe[k-1];
      end
   end
   assign res_data = mv_pipe[LAT-1] ? md_pipe[LAT-1] : 34'h3_FFFF_FFFF;
   assign res_exc  = mv_pipe[LAT-1] ? me_pipe[LAT-1] : garbage_exc;

   function automatic logic [33:0] exp_wb(input int j, input logic m);
      return {1'b1, m, 32'h1000_0A00 | 32'(j)};
   endfunction

   // Presents an op and returns at the negedge of cycle t0+1.
   task automatic launch(input logic [4:0] v, input logic [1:0] r);
      @(negedge clk);
      start_valid = 1'b1;
      vl          = v;
      rnd         = r;
      for (int k = 0; k < 60; k++) begin
         if (start_ready) break;
         @(negedge clk);
      end
      if (!start_ready) begin
         n_tests++; n_fail++;
         $display("FAIL launch_timeout start_ready=%b want 1", start_ready);
      end
      @(negedge clk);
      start_valid = 1'b0;
   endtask

   task automatic test_reset;
      logic [6:0] got;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      got = {busy, done, rd_en, wb_en, mul_valid, exc_flag, start_ready};
      n_tests++;
      if (got !== 7'b0000001) begin
         n_fail++;
         $display("FAIL reset_ctrl got %b want 0000001", got);
      end
      n_tests++;
      if ({mul_a, mul_b, wb_data, wb_idx, rd_idx, mul_rnd} !== '0) begin
         n_fail++;
         $display("FAIL reset_data got mul_a=%h wb_data=%h want 0", mul_a, wb_data);
      end
      rst = 1'b0;
      $display("[TB] reset: start_ready=%b busy=%b", start_ready, busy);
   endtask

   task automatic test_basic;
      launch(5'd4, 2'b01);
      for (int k = 1; k <= 11; k++) begin
         logic e_rd, e_mul, e_wb;
         e_rd  = (k >= 1 && k <= 4);
         e_mul = (k >= 2 && k <= 5);
         e_wb  = (k >= 5 && k <= 8);
         n_tests++;
         if (rd_en !== e_rd || (e_rd && rd_idx !== 4'(k - 1))) begin
            n_fail++;
            $display("FAIL basic_rd k=%0d got %b/%0d want %b/%0d", k, rd_en, rd_idx, e_rd, k - 1);
         end
         n_tests++;
         if (mul_valid !== e_mul || (e_mul && (mul_rnd !== 2'b01 || mul_a !== (32'h1000_0000 | 32'(k - 2))))) begin
            n_fail++;
            $display("FAIL basic_mul k=%0d got %b rnd=%b a=%h want %b rnd=01", k, mul_valid, mul_rnd, mul_a, e_mul);
         end
         n_tests++;
         if (wb_en !== e_wb || (e_wb && (wb_idx !== 4'(k - 5) || wb_data !== exp_wb(k - 5, 1'b1)))) begin
            n_fail++;
            $display("FAIL basic_wb k=%0d got %b/%0d/%h want %b/%0d", k, wb_en, wb_idx, wb_data, e_wb, k - 5);
         end
         n_tests++;
         if ({done, busy, start_ready, exc_flag} !== {k == 9, k <= 9, k >= 10, 1'b0}) begin
            n_fail++;
            $display("FAIL basic_ctrl k=%0d got done/busy/ready/exc=%b%b%b%b want %b%b%b0",
                     k, done, busy, start_ready, exc_flag, k == 9, k <= 9, k >= 10);
         end
         @(negedge clk);
      end
      $display("[TB] basic vl=4 rnd=01 complete");
   endtask

   task automatic test_exc;
      exc_en  = 1'b1;
      exc_sel = 4'd7;
      launch(5'd16, 2'b10);
      for (int k = 1; k <= 24; k++) begin
         n_tests++;
         if (exc_flag !== (k >= 12)) begin
            n_fail++;
            $display("FAIL exc_flag k=%0d got %b want %b", k, exc_flag, k >= 12);
         end
         if (k == 21 || k == 22) begin
            n_tests++;
            if (done !== (k == 21)) begin
               n_fail++;
               $display("FAIL exc_done k=%0d got %b want %b", k, done, k == 21);
            end
         end
         @(negedge clk);
      end
      exc_en = 1'b0;
      $display("[TB] exc vl=16 exc on idx 7, exc_flag=%b after done", exc_flag);
   endtask

   task automatic test_vl0;
      launch(5'd0, 2'b00);
      n_tests++;
      if ({done, busy, rd_en, wb_en, start_ready, exc_flag} !== 6'b110000) begin
         n_fail++;
         $display("FAIL vl0_t1 got done/busy/rd/wb/ready/exc=%b%b%b%b%b%b want 110000",
                  done, busy, rd_en, wb_en, start_ready, exc_flag);
      end
      @(negedge clk);
      n_tests++;
      if ({done, busy, rd_en, wb_en, start_ready} !== 5'b00001) begin
         n_fail++;
         $display("FAIL vl0_t2 got done/busy/rd/wb/ready=%b%b%b%b%b want 00001",
                  done, busy, rd_en, wb_en, start_ready);
      end
      $display("[TB] vl0 complete");
   endtask

   task automatic test_rst_mid;
      int bad;
      launch(5'd8, 2'b11);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      n_tests++;
      if ({start_ready, busy} !== 2'b10) begin
         n_fail++;
         $display("FAIL rst_mid_ready got ready/busy=%b%b want 10", start_ready, busy);
      end
      bad = 0;
      for (int k = 0; k < 16; k++) begin
         if (wb_en || done || rd_en || mul_valid) bad++;
         @(negedge clk);
      end
      n_tests++;
      if (bad !== 0) begin
         n_fail++;
         $display("FAIL rst_mid_quiet got %0d active cycles want 0", bad);
      end
      $display("[TB] reset mid-op discarded vl=8");
   endtask

   task automatic test_clamp;
      int rd_cnt, wb_cnt, done_k, last_idx;
      rd_cnt = 0; wb_cnt = 0; done_k = -1; last_idx = -1;
      launch(5'd20, 2'b00);
      for (int k = 1; k <= 23; k++) begin
         if (rd_en) begin rd_cnt++; last_idx = int'(rd_idx); end
         if (wb_en) wb_cnt++;
         if (done) done_k = k;
         @(negedge clk);
      end
      n_tests++;
      if (rd_cnt !== 16 || last_idx !== 15) begin
         n_fail++;
         $display("FAIL clamp_rd got %0d reads last %0d want 16 last 15", rd_cnt, last_idx);
      end
      n_tests++;
      if (wb_cnt !== 16) begin
         n_fail++;
         $display("FAIL clamp_wb got %0d want 16", wb_cnt);
      end
      n_tests++;
      if (done_k !== 21) begin
         n_fail++;
         $display("FAIL clamp_done got cycle %0d want 21", done_k);
      end
      $display("[TB] clamp vl=20 -> %0d elements", rd_cnt);
   endtask

   task automatic test_mask;
      mask_pat = 16'h000A;
      launch(5'd4, 2'b01);
      for (int k = 1; k <= 10; k++) begin
         logic e_mul, e_wb, m_mul, m_wb;
         m_mul = (k >= 2 && k <= 5) ? mask_pat[k-2] : 1'b0;
         m_wb  = (k >= 5 && k <= 8) ? mask_pat[k-5] : 1'b0;
`ifdef VMUL_SEQ_MASK_EN
         e_mul = m_mul;
         e_wb  = m_wb;
`else
         e_mul = (k >= 2 && k <= 5);
         e_wb  = (k >= 5 && k <= 8);
`endif
         n_tests++;
         if (mul_valid !== e_mul || (e_mul && mul_mask !== m_mul)) begin
            n_fail++;
            $display("FAIL mask_mul k=%0d got %b/%b want %b/%b", k, mul_valid, mul_mask, e_mul, m_mul);
         end
         n_tests++;
         if (wb_en !== e_wb || (e_wb && (wb_idx !== 4'(k - 5) || wb_data !== exp_wb(k - 5, m_wb)))) begin
            n_fail++;
            $display("FAIL mask_wb k=%0d got %b/%0d/%h want %b/%0d", k, wb_en, wb_idx, wb_data, e_wb, k - 5);
         end
         n_tests++;
         if (done !== (k == 9) || exc_flag !== 1'b0) begin
            n_fail++;
            $display("FAIL mask_done k=%0d got done=%b exc=%b want %b 0", k, done, exc_flag, k == 9);
         end
         @(negedge clk);
      end
      mask_pat = 16'hFFFF;
      $display("[TB] mask 1010 vl=4 complete");
   endtask

   task automatic test_back_to_back;
      int acc_q[$];
      int done_q[$];
      int wbc_q[$];
      int wbi_q[$];
      @(negedge clk);
      start_valid = 1'b1;
      vl          = 5'd2;
      rnd         = 2'b00;
      for (int c = 0; c <= 15; c++) begin
         if (start_valid && start_ready) acc_q.push_back(c);
         if (done) done_q.push_back(c);
         if (wb_en) begin wbc_q.push_back(c); wbi_q.push_back(int'(wb_idx)); end
         if (c == 15) start_valid = 1'b0;
         @(negedge clk);
      end
      n_tests++;
      if (acc_q.size() !== 2 || acc_q[0] !== 0 || acc_q[1] !== 8) begin
         n_fail++;
         $display("FAIL b2b_accept got n=%0d first=%0d second=%0d want 2 0 8",
                  acc_q.size(), acc_q.size() > 0 ? acc_q[0] : -1, acc_q.size() > 1 ? acc_q[1] : -1);
      end
      n_tests++;
      if (done_q.size() !== 2 || done_q[0] !== 7 || done_q[1] !== 15) begin
         n_fail++;
         $display("FAIL b2b_done got n=%0d first=%0d want 2 7 15",
                  done_q.size(), done_q.size() > 0 ? done_q[0] : -1);
      end
      n_tests++;
      if (wbc_q.size() !== 4 || wbc_q[0] !== 5 || wbc_q[1] !== 6 || wbc_q[2] !== 13 || wbc_q[3] !== 14 ||
          wbi_q[0] !== 0 || wbi_q[1] !== 1 || wbi_q[2] !== 0 || wbi_q[3] !== 1) begin
         n_fail++;
         $display("FAIL b2b_wb got n=%0d want cycles 5,6,13,14 idx 0,1,0,1", wbc_q.size());
      end
      $display("[TB] back-to-back vl=2 accepts=%0d", acc_q.size());
   endtask

   initial begin
      test_reset();
      test_basic();
      test_exc();
      test_vl0();
      test_rst_mid();
      test_clamp();
      test_mask();
      test_back_to_back();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vmul_sequencer.md
VMUL_SEQUENCER -- requirements
Module: vmul_sequencer

Interface
REQ-001 SHALL have parameter MAX_VL, default 16, maximum elements per vector op.
REQ-002 SHALL have parameter MUL_LAT, default 3, fixed cycles from mul_valid to res_data/res_exc.
REQ-003 SHALL have one clock and a synchronous, active-high reset: ports clk and rst.
REQ-004 clk  in  1  clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 start_valid  in  1  op request; start_ready  out  1  op accepted when both high.
REQ-007 vl  in  5  element count, 0..MAX_VL; rnd  in  2  rounding code, same encoding as the multiplier.
REQ-008 rd_en  out  1  / rd_idx  out  4  register-file element read; rd_a, rd_b  in  32  / rd_mask  in  1  valid one cycle after rd_en.
REQ-009 mul_valid  out  1; mul_a, mul_b  out  32; mul_mask  out  1; mul_rnd  out  2  multiplier issue.
REQ-010 res_data  in  34  {valid, mask, sign, exp[7:0], frac[22:0]}; res_exc  in  1  multiplier exception.
REQ-011 wb_en  out  1; wb_idx  out  4; wb_data  out  34  destination write port.
REQ-012 busy  out  1; done  out  1  single-cycle pulse; exc_flag  out  1  sticky exception.

Function
REQ-013 SHALL use FSM states IDLE, ISSUE, DRAIN, DONE; start_ready=1 only in IDLE.
REQ-014 On acceptance (cycle t0): latch vl, latch rnd, clear exc_flag; go to ISSUE when vl>0, or DONE when vl=0.
REQ-015 ISSUE: rd_en=1 with rd_idx=i at cycle t0+1+i for i=0..vl-1, one per cycle, no bubbles; go to DRAIN after idx vl-1.
REQ-016 mul_valid=1 at t0+2+i, with mul_a/mul_b/mul_mask registered from the RF read data and mul_rnd=latched rnd.
REQ-017 SHALL track in-flight elements with a MUL_LAT-deep valid+index delay line; wb_en=1, wb_idx=i, wb_data=res_data at t0+2+i+MUL_LAT.
REQ-018 exc_flag |= res_exc on every cycle a tracked result emerges; it holds after done until the next acceptance or reset.
REQ-019 DRAIN exits to DONE the cycle after the last writeback; DONE asserts done=1 for exactly one cycle, then returns to IDLE.
REQ-020 busy=1 in ISSUE, DRAIN and DONE; busy=0 in IDLE.
REQ-021 vl>MAX_VL SHALL be clamped to MAX_VL at acceptance.
REQ-022 start_valid while busy is ignored and does not disturb the op in progress; a new op may be accepted in the cycle after DONE.
REQ-023 res_data/res_exc SHALL be ignored in cycles with no tracked element emerging.

Reset
REQ-024 rst SHALL force IDLE, clear counters, the delay line and exc_flag; every output 0 except start_ready=1.
REQ-025 rst mid-op SHALL discard in-flight results: no wb_en and no done pulse for the aborted op.

Configuration
REQ-026 Macro VMUL_SEQ_MASK_EN defined: elements with rd_mask=0 produce mul_valid=0 and wb_en=0 and contribute nothing to exc_flag, while keeping their issue and writeback slot timing.
REQ-027 Macro VMUL_SEQ_MASK_EN undefined: mask is forwarded on mul_mask only; every element issues and writes back.

Structure
REQ-028 Package vmul_seq_pkg SHALL hold the state encoding, MAX_VL/MUL_LAT defaults, and the res_data field bit positions (33 valid, 32 mask, 31 sign, 30:23 exp, 22:0 frac).
REQ-029 Sub-module vmul_seq_track SHALL implement the valid/index delay line; the FSM and counters stay in vmul_sequencer.

Verification
REQ-030 vl=4, rnd=01, MUL_LAT=3, start at t0: rd_idx 0..3 at t0+1..t0+4; wb_idx 0..3 at t0+5..t0+8; done at t0+9.
REQ-031 vl=0: no rd_en, no wb_en; done at t0+1; start_ready=1 at t0+2.
REQ-032 vl=16, res_exc=1 on element 7 only: exc_flag=1 from the wb cycle of element 7, still 1 after done, cleared at next start.
REQ-033 rst asserted at t0+3 with vl=8: no further wb_en, no done; start_ready=1 the cycle after rst.
REQ-034 VMUL_SEQ_MASK_EN with mask=1010 (elements 0..3): wb_en only for idx 1 and 3; done timing is the same as REQ-030.
REQ-035 start_valid held high throughout and after vl=2: the second op is accepted the cycle after done, with no overlap of wb_idx.
